// File: rtl/bioz_iq_accumulator.sv
// BioZ I/Q demodulation accumulator: multiplies synchronized ADC samples by the
// +/-1 IP/QP references and sums them over a programmable number of IP periods.
module bioz_iq_accumulator #(
    parameter int DW = 12,
    parameter int AW = 24,
    parameter int PW = 8
) (
    input  logic          Clk,
    input  logic          Resetn,
    input  logic          Enable,
    input  logic [DW-1:0] SampleIn,
    input  logic          SampleValid,
    input  logic          IP,
    input  logic          QP,
    input  logic [PW-1:0] NumPeriods,
    output logic [AW-1:0] ISum,
    output logic [AW-1:0] QSum,
    output logic          ResultValid,
    input  logic          ResultReady,
    output logic          Saturated,
    output logic          Overrun,
    output logic          Busy,
    output logic [1:0]    DbgState
);

    // Result port handshake: a frame transfers on any cycle where ResultValid
    // and ResultReady are both 1; ISum/QSum/Saturated never change while
    // ResultValid is 1 unless that same cycle is a transfer.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    state_t               state_q;
    logic                 ip1_q, ip2_q, ip3_q;
    logic                 qp1_q, qp2_q;
    logic                 sv1_q, sv2_q;
    logic signed [DW-1:0] smp1_q, smp2_q;
    logic signed [AW-1:0] i_acc_q, q_acc_q;
    logic signed [AW-1:0] isum_q, qsum_q;
    logic                 sat_q, rvalid_q, rsat_q, overrun_q;
    logic [PW-1:0]        pcnt_q, nper_q;

    logic signed [AW-1:0] x_ext, i_term, q_term, i_acc_d, q_acc_d;
    logic signed [AW:0]   i_wide, q_wide;
    logic                 ip_rise, i_ovf, q_ovf, frame_end, load_out;
    logic [PW-1:0]        nper_in;

    // Samples ride the same two stages as IP/QP so they stay phase-aligned.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            ip1_q  <= 1'b0;
            ip2_q  <= 1'b0;
            ip3_q  <= 1'b0;
            qp1_q  <= 1'b0;
            qp2_q  <= 1'b0;
            sv1_q  <= 1'b0;
            sv2_q  <= 1'b0;
            smp1_q <= '0;
            smp2_q <= '0;
        end else begin
            ip1_q  <= IP;
            ip2_q  <= ip1_q;
            ip3_q  <= ip2_q;
            qp1_q  <= QP;
            qp2_q  <= qp1_q;
            sv1_q  <= SampleValid;
            sv2_q  <= sv1_q;
            smp1_q <= SampleIn;
            smp2_q <= smp1_q;
        end
    end

    assign ip_rise = ip2_q & ~ip3_q;
    assign x_ext   = {{(AW-DW){smp2_q[DW-1]}}, smp2_q};
    assign i_term  = !sv2_q ? '0 : (ip2_q ? x_ext : -x_ext);
    assign q_term  = !sv2_q ? '0 : (qp2_q ? x_ext : -x_ext);

    // One guard bit detects overflow; the sign of the wide sum picks the rail.
    assign i_wide  = {i_acc_q[AW-1], i_acc_q} + {i_term[AW-1], i_term};
    assign q_wide  = {q_acc_q[AW-1], q_acc_q} + {q_term[AW-1], q_term};
    assign i_ovf   = i_wide[AW] ^ i_wide[AW-1];
    assign q_ovf   = q_wide[AW] ^ q_wide[AW-1];
    assign i_acc_d = i_ovf ? (i_wide[AW] ? ACC_MIN : ACC_MAX) : i_wide[AW-1:0];
    assign q_acc_d = q_ovf ? (q_wide[AW] ? ACC_MIN : ACC_MAX) : q_wide[AW-1:0];

    assign nper_in   = (NumPeriods == '0) ? PW'(1) : NumPeriods;
    assign frame_end = (state_q == S_ACC) && Enable && ip_rise &&
                       ((pcnt_q + PW'(1)) == nper_q);
    assign load_out  = frame_end && (!rvalid_q || ResultReady);

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            i_acc_q   <= '0;
            q_acc_q   <= '0;
            sat_q     <= 1'b0;
            pcnt_q    <= '0;
            nper_q    <= PW'(1);
            isum_q    <= '0;
            qsum_q    <= '0;
            rsat_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (load_out) begin
                isum_q   <= i_acc_q;
                qsum_q   <= q_acc_q;
                rsat_q   <= sat_q;
                rvalid_q <= 1'b1;
            end else begin
                if (frame_end) overrun_q <= 1'b1;
                if (ResultReady) rvalid_q <= 1'b0;
            end
            if (state_q == S_IDLE && !Enable) overrun_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    i_acc_q <= '0;
                    q_acc_q <= '0;
                    sat_q   <= 1'b0;
                    pcnt_q  <= '0;
                    if (Enable) state_q <= S_ARM;
                end
                S_ARM: begin
                    if (!Enable) begin
                        state_q <= S_IDLE;
                    end else if (ip_rise) begin
                        state_q <= S_ACC;
                        nper_q  <= nper_in;
                        pcnt_q  <= '0;
                        i_acc_q <= i_term;
                        q_acc_q <= q_term;
                        sat_q   <= 1'b0;
                    end
                end
                S_ACC: begin
                    if (!Enable) begin
                        state_q <= S_IDLE;
                    end else if (frame_end) begin
                        // Edge-cycle sample opens the next frame, no gap.
                        nper_q  <= nper_in;
                        pcnt_q  <= '0;
                        i_acc_q <= i_term;
                        q_acc_q <= q_term;
                        sat_q   <= 1'b0;
                    end else begin
                        i_acc_q <= i_acc_d;
                        q_acc_q <= q_acc_d;
                        sat_q   <= sat_q | i_ovf | q_ovf;
                        if (ip_rise) pcnt_q <= pcnt_q + PW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ISum        = isum_q;
    assign QSum        = qsum_q;
    assign ResultValid = rvalid_q;
    assign Saturated   = rsat_q;
    assign Overrun     = overrun_q;
    assign Busy        = (state_q == S_ARM) || (state_q == S_ACC);
    assign DbgState    = state_q;

endmodule

// File: doc/bioz_iq_accumulator.md
# bioz_iq_accumulator

Downstream I/Q demodulation accumulator for the BioZ measurement path. It takes signed ADC samples of the electrode response and the in-phase/quadrature reference square waves (IP, QP) produced by the DAC signal-generator controller. Each sample is multiplied by ±1 according to the reference level, and I and Q sums are accumulated over a programmable number of reference periods. The finished I/Q frame is presented on a valid/ready output port to the readout logic.

## Interface
Parameters:
- DW, 12, SampleIn width (two's complement)
- AW, 24, accumulator/result width (two's complement), AW > DW
- PW, 8, NumPeriods width

Ports:
- Clk  input  1  system clock
- Resetn  input  1  reset, asynchronous, active-low
- Enable  input  1  run request; low aborts the current frame
- SampleIn  input  DW  signed ADC sample
- SampleValid  input  1  SampleIn valid this cycle
- IP  input  1  in-phase reference (may be asynchronous to Clk)
- QP  input  1  quadrature reference (may be asynchronous to Clk)
- NumPeriods  input  PW  IP periods per frame; 0 is treated as 1
- ISum  output  AW  in-phase result
- QSum  output  AW  quadrature result
- ResultValid  output  1  ISum/QSum hold an unconsumed frame
- ResultReady  input  1  consumer accepts the frame
- Saturated  output  1  the frame held in ISum/QSum clipped in I or Q
- Overrun  output  1  sticky; a completed frame was dropped
- Busy  output  1  FSM is in ARM or ACC

## Operation
- Input alignment: IP, QP, SampleIn and SampleValid pass through an identical 2-stage register pipeline (stage-1 regs form the IP/QP synchronizer). A 3rd register on IP (IP3) supports edge detection. Rising edge: IP2 & ~IP3.
- FSM states:
  - IDLE: accumulators cleared. Enable=1 -> ARM.
  - ARM: wait for an IP rising edge. On the edge, latch NumPeriods (max(1, NumPeriods)) into nper, set pcnt=0, and go to ACC. A sample valid on the edge cycle is accumulated as the first sample of the frame.
  - ACC: on every aligned SampleValid:
    - I_acc += IP2 ? +x : −x
    - Q_acc += QP2 ? +x : −x
    - x is sign-extended to AW.
  - ACC, on each IP rising edge: pcnt += 1. When pcnt+1 == nper, the frame ends.
- Frame end (ACC):
  - The pre-edge accumulator values are offered to the output register.
  - The accumulators restart with the edge-cycle sample's contribution only (or 0 if none), and pcnt=0. No gap between frames.
  - nper is re-latched from NumPeriods.
- Arithmetic: saturate at +(2^(AW−1)−1) / −2^(AW−1). Any clip sets a frame-local sat flag, which is copied to Saturated with the frame.
- Output register:
  - Loads at frame end when ResultValid=0, or when ResultValid=1 and ResultReady=1 in the same cycle (ResultValid then stays 1).
  - Otherwise the new frame is discarded, the held frame is kept, and Overrun is set.
  - ResultValid clears on ResultReady=1 with no simultaneous load.
  - ISum/QSum/Saturated remain stable while ResultValid=1.
- Enable=0 in ARM or ACC -> IDLE next cycle. The partial frame is discarded and not flagged. The held output frame and ResultValid are unaffected. Overrun clears only while in IDLE with Enable=0.
- Busy = (state == ARM) or (state == ACC).

## Timing
- Reset values: ISum=0, QSum=0, ResultValid=0, Saturated=0, Overrun=0, Busy=0, state IDLE, all pipeline regs 0.
- Input-to-accumulator latency: 2 Clk (pipeline) plus 1 Clk (accumulate register).
- IP edge at the pins -> earliest detection is 3 Clk later.
- Frame-end detection cycle N -> ISum/QSum/ResultValid update at N+1.
- Enable rise -> Busy=1 next cycle. Enable fall -> Busy=0 next cycle.
- IP must stay high and low for ≥2 Clk each. Shorter pulses may be missed.
- Full throughput: SampleValid may be 1 every cycle.

## Test plan
1. DW=12, AW=24, NumPeriods=4. IP period 32 Clk (16 high / 16 low), QP lagging 8 Clk. SampleValid every cycle, sample = +100 while IP=1, −100 while IP=0, aligned at the pins. Required: ISum=12800, QSum=0, ResultValid rises 1 Clk after the 4th post-arm edge detection, and frames then repeat back to back.
2. Same stimulus, ResultReady held 0 across two frame ends. Required: first frame held unchanged and Overrun=1. Then pulse ResultReady on the cycle of the 3rd frame end. Required: output loads the new frame and ResultValid stays 1.
3. NumPeriods=0, constant sample +2047 every cycle, IP period 32. Required: one frame per IP period, ISum=0, QSum=0, Saturated=0.
4. AW=13, sample +2047 while IP=1 and −2048 while IP=0, NumPeriods=4. Required: ISum=4095 (positive saturation limit), Saturated=1.
5. Drop Enable mid-frame, then raise it again. Required: Busy=0 next cycle. The re-armed frame starts at the next IP edge and yields the full-frame value, with no residue from the aborted frame.
6. Assert Resetn low mid-frame while ResultValid=1. Required: all outputs 0 immediately (asynchronously). After release with Enable=1, the FSM passes through ARM before accumulating.
